prirv32_instr_encoder: RTL and testbench
========================================

# prirv32_instr_encoder

Encodes RV32I instruction fields (operation, rd, rs1, rs2, immediate in the decoded form produced by the IFU decoder) back into 32-bit instruction words. Requests enter over a valid/ready handshake. Encoded words leave through a FIFO with valid/ready backpressure, with an error flag per word. It sits between the debug/self-test program generator and instruction memory, and is the encoding counterpart to the IFU decoder.

## Interface
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2
- clk_in  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid && ready at clock edge
- req_op_i  in  6  operation code (see Operation)
- req_rd_i / req_rs1_i / req_rs2_i  in  5 each  register fields; rs1 carries uimm for CSR*I
- req_imm_i  in  32  immediate, decoded form: sign-extended byte offset; U-type full value; CSR address in [11:0]
- out_valid_o  out  1  encoded word available
- out_ready_i  in  1  consumer takes word when valid && ready
- out_instr_o  out  32  encoded word; 0 when out_valid_o=0
- out_err_o  out  1  word is an encoding error; 0 when out_valid_o=0
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  entries held
- err_count_o  out  8  accepted erroneous requests, saturating at 255

## Operation
- Op codes: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4–9 BEQ BNE BLT BGE BLTU BGEU, 10–14 LB LH LW LBU LHU, 15–17 SB SH SW, 18–26 ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI, 27–36 ADD SUB SLL SLT SLTU XOR SRL SRA OR AND, 37 FENCE, 38 FENCE.I, 39 ECALL, 40 EBREAK, 41–46 CSRRW CSRRS CSRRC CSRRWI CSRRSI CSRRCI, 47–63 illegal.
- Opcodes and funct3 values are the standard RV32I values. SUB and SRA/SRAI use funct7 0100000. All other R-type ops and shifts use 0000000.
- Encoding is combinational from request inputs. The result is written into the FIFO on an accepted request.
- Immediate range rules; violation → error:
  - I/S-type, FENCE.I: imm must equal sign-extension of imm[11:0].
  - B: imm[0]=0 and imm fits 13-bit signed.
  - J: imm[0]=0 and imm fits 21-bit signed.
  - U: imm[11:0]=0.
  - Shift-immediate: imm[31:5]=0.
  - CSR*, FENCE: imm[31:12]=0.
- FENCE: imm[11:0]→[31:20]; rd and rs1 fields from inputs.
- ECALL=32'h00000073 and EBREAK=32'h00100073; other fields are ignored.
- Error (illegal op or range violation): FIFO entry is word 32'h00000000 with err=1. err_count_o increments, saturating.
- FIFO: in-order, no drop, no reordering.
  - req_ready_o = (level != FIFO_DEPTH).
  - Push and pop in the same cycle: level unchanged.
  - No push when full, even if a pop occurs that cycle; there is no bypass.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (asynchronous, immediate on rst_n low):
  - level=0, pointers=0, err_count_o=0
  - out_valid_o=0, out_instr_o=0, out_err_o=0
  - req_ready_o=1
- Reset mid-operation discards all FIFO contents.
- Latency: a request accepted at edge N appears at out_valid_o/out_instr_o after edge N, if the FIFO was empty.
- Throughput: one word per cycle with out_ready_i held high.
- req_ready_o and out_valid_o depend only on registered level; there is no combinational path from req_valid_i or out_ready_i.
- err_count_o updates at the accepting edge.

## Test plan
- ADDI rd=1 rs1=2 imm=32'hFFFFFFFF → 32'hFFF10093, err=0; SUB rd=3 rs1=1 rs2=2 → 32'h402081B3.
- BEQ rs1=1 rs2=2 imm=32'hFFFFFFFC → 32'hFE208EE3; JAL rd=1 imm=32'h800 → 32'h001000EF; JAL imm=32'h801 → 32'h00000000, err=1.
- LUI rd=5 imm=32'h12345000 → 32'h123452B7; LUI imm=32'h12345001 → err=1, err_count_o=1; op=50 → err=1, err_count_o=2.
- FIFO_DEPTH=4, out_ready_i=0, five back-to-back requests:
  - req_ready_o=0 after the 4th accept; fifo_level_o=4.
  - Then out_ready_i=1: four words drain in order, one per cycle; the 5th request is accepted the cycle after the first pop.
- Simultaneous push/pop at level 2 → level stays 2 and order is preserved. With 256 erroneous requests, err_count_o holds at 255.
- rst_n low mid-burst at level 3 → immediately out_valid_o=0, fifo_level_o=0, err_count_o=0, req_ready_o=1. After release, the next word is the first post-reset request.

Source files
------------

// File: rtl/prirv32_instr_encoder.sv
// RV32I instruction encoder: turns decoded operation/register/immediate fields back into
// 32-bit instruction words and queues them, with a per-word error flag, in an output FIFO.
module prirv32_instr_encoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [5:0]                    req_op_i,
  input  logic [4:0]                    req_rd_i,
  input  logic [4:0]                    req_rs1_i,
  input  logic [4:0]                    req_rs2_i,
  input  logic [31:0]                   req_imm_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [31:0]                   out_instr_o,
  output logic                          out_err_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [7:0]                    err_count_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcFence  = 7'b0001111;
  localparam logic [6:0] OpcSystem = 7'b1110011;
  localparam logic [6:0] F7Alt     = 7'b0100000;

  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtSh, FmtFix} fmt_e;
  typedef enum logic [2:0] {ChkNone, ChkI, ChkB, ChkJ, ChkU, ChkSh, ChkHi} chk_e;

  fmt_e        fmt;
  chk_e        chk;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        illegal;
  logic [31:0] fix_word;

  always_comb begin
    fmt      = FmtR;
    chk      = ChkNone;
    opc      = 7'b0;
    f3       = 3'b000;
    f7       = 7'b0;
    illegal  = 1'b0;
    fix_word = 32'h0000_0000;
    case (req_op_i)
      6'd0:  begin fmt = FmtU; chk = ChkU; opc = OpcLui;   end
      6'd1:  begin fmt = FmtU; chk = ChkU; opc = OpcAuipc; end
      6'd2:  begin fmt = FmtJ; chk = ChkJ; opc = OpcJal;   end
      6'd3:  begin fmt = FmtI; chk = ChkI; opc = OpcJalr;  end
      6'd4:  begin fmt = FmtB; chk = ChkB; opc = OpcBranch; f3 = 3'b000; end
      6'd5:  begin fmt = FmtB; chk = ChkB; opc = OpcBranch; f3 = 3'b001; end
      6'd6:  begin fmt = FmtB; chk = ChkB; opc = OpcBranch; f3 = 3'b100; end
      6'd7:  begin fmt = FmtB; chk = ChkB; opc = OpcBranch; f3 = 3'b101; end
      6'd8:  begin fmt = FmtB; chk = ChkB; opc = OpcBranch; f3 = 3'b110; end
      6'd9:  begin fmt = FmtB; chk = ChkB; opc = OpcBranch; f3 = 3'b111; end
      6'd10: begin fmt = FmtI; chk = ChkI; opc = OpcLoad; f3 = 3'b000; end
      6'd11: begin fmt = FmtI; chk = ChkI; opc = OpcLoad; f3 = 3'b001; end
      6'd12: begin fmt = FmtI; chk = ChkI; opc = OpcLoad; f3 = 3'b010; end
      6'd13: begin fmt = FmtI; chk = ChkI; opc = OpcLoad; f3 = 3'b100; end
      6'd14: begin fmt = FmtI; chk = ChkI; opc = OpcLoad; f3 = 3'b101; end
      6'd15: begin fmt = FmtS; chk = ChkI; opc = OpcStore; f3 = 3'b000; end
      6'd16: begin fmt = FmtS; chk = ChkI; opc = OpcStore; f3 = 3'b001; end
      6'd17: begin fmt = FmtS; chk = ChkI; opc = OpcStore; f3 = 3'b010; end
      6'd18: begin fmt = FmtI; chk = ChkI; opc = OpcOpImm; f3 = 3'b000; end
      6'd19: begin fmt = FmtI; chk = ChkI; opc = OpcOpImm; f3 = 3'b010; end
      6'd20: begin fmt = FmtI; chk = ChkI; opc = OpcOpImm; f3 = 3'b011; end
      6'd21: begin fmt = FmtI; chk = ChkI; opc = OpcOpImm; f3 = 3'b100; end
      6'd22: begin fmt = FmtI; chk = ChkI; opc = OpcOpImm; f3 = 3'b110; end
      6'd23: begin fmt = FmtI; chk = ChkI; opc = OpcOpImm; f3 = 3'b111; end
      6'd24: begin fmt = FmtSh; chk = ChkSh; opc = OpcOpImm; f3 = 3'b001; end
      6'd25: begin fmt = FmtSh; chk = ChkSh; opc = OpcOpImm; f3 = 3'b101; end
      6'd26: begin fmt = FmtSh; chk = ChkSh; opc = OpcOpImm; f3 = 3'b101; f7 = F7Alt; end
      6'd27: begin opc = OpcOp; f3 = 3'b000; end
      6'd28: begin opc = OpcOp; f3 = 3'b000; f7 = F7Alt; end
      6'd29: begin opc = OpcOp; f3 = 3'b001; end
      6'd30: begin opc = OpcOp; f3 = 3'b010; end
      6'd31: begin opc = OpcOp; f3 = 3'b011; end
      6'd32: begin opc = OpcOp; f3 = 3'b100; end
      6'd33: begin opc = OpcOp; f3 = 3'b101; end
      6'd34: begin opc = OpcOp; f3 = 3'b101; f7 = F7Alt; end
      6'd35: begin opc = OpcOp; f3 = 3'b110; end
      6'd36: begin opc = OpcOp; f3 = 3'b111; end
      6'd37: begin fmt = FmtI; chk = ChkHi; opc = OpcFence; f3 = 3'b000; end
      6'd38: begin fmt = FmtI; chk = ChkI;  opc = OpcFence; f3 = 3'b001; end
      6'd39: begin fmt = FmtFix; fix_word = 32'h0000_0073; end
      6'd40: begin fmt = FmtFix; fix_word = 32'h0010_0073; end
      6'd41: begin fmt = FmtI; chk = ChkHi; opc = OpcSystem; f3 = 3'b001; end
      6'd42: begin fmt = FmtI; chk = ChkHi; opc = OpcSystem; f3 = 3'b010; end
      6'd43: begin fmt = FmtI; chk = ChkHi; opc = OpcSystem; f3 = 3'b011; end
      6'd44: begin fmt = FmtI; chk = ChkHi; opc = OpcSystem; f3 = 3'b101; end
      6'd45: begin fmt = FmtI; chk = ChkHi; opc = OpcSystem; f3 = 3'b110; end
      6'd46: begin fmt = FmtI; chk = ChkHi; opc = OpcSystem; f3 = 3'b111; end
      default: illegal = 1'b1;
    endcase
  end

  // Immediate range checks; "all same" means the upper bits are a pure sign extension.
  logic [31:0] imm;
  logic        i_ok, b_ok, j_ok, u_ok, sh_ok, hi_ok, range_ok;

  assign imm   = req_imm_i;
  assign i_ok  = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_ok  = ~imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
  assign j_ok  = ~imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));
  assign u_ok  = ~(|imm[11:0]);
  assign sh_ok = ~(|imm[31:5]);
  assign hi_ok = ~(|imm[31:12]);

  always_comb begin
    range_ok = 1'b1;
    case (chk)
      ChkI:    range_ok = i_ok;
      ChkB:    range_ok = b_ok;
      ChkJ:    range_ok = j_ok;
      ChkU:    range_ok = u_ok;
      ChkSh:   range_ok = sh_ok;
      ChkHi:   range_ok = hi_ok;
      default: range_ok = 1'b1;
    endcase
  end

  logic [31:0] enc_word;
  logic        enc_err;

  always_comb begin
    enc_word = 32'h0000_0000;
    case (fmt)
      FmtR:   enc_word = {f7, req_rs2_i, req_rs1_i, f3, req_rd_i, opc};
      FmtI:   enc_word = {imm[11:0], req_rs1_i, f3, req_rd_i, opc};
      FmtS:   enc_word = {imm[11:5], req_rs2_i, req_rs1_i, f3, imm[4:0], opc};
      FmtB:   enc_word = {imm[12], imm[10:5], req_rs2_i, req_rs1_i, f3, imm[4:1], imm[11], opc};
      FmtU:   enc_word = {imm[31:12], req_rd_i, opc};
      FmtJ:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], req_rd_i, opc};
      FmtSh:  enc_word = {f7, imm[4:0], req_rs1_i, f3, req_rd_i, opc};
      FmtFix: enc_word = fix_word;
      default: enc_word = 32'h0000_0000;
    endcase
  end

  assign enc_err = illegal | ~range_ok;

  // Output FIFO
  logic [32:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q, level_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              push, pop;

  assign req_ready_o = (level_q != LevelW'(FIFO_DEPTH));
  assign out_valid_o = (level_q != '0);
  assign push        = req_valid_i & req_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    err_count_d = err_count_q;
    if (push && enc_err && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      err_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q     <= level_d;
      err_count_q <= err_count_d;
    end
  end

  // Storage needs no reset: entries are only observed through a nonzero level.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc_err ? {1'b1, 32'h0000_0000} : {1'b0, enc_word};
    end
  end

  assign out_instr_o  = out_valid_o ? mem_q[rd_ptr_q][31:0] : 32'h0000_0000;
  assign out_err_o    = out_valid_o & mem_q[rd_ptr_q][32];
  assign fifo_level_o = level_q;
  assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_prirv32_instr_encoder.sv
// Directed self-checking bench for prirv32_instr_encoder: hand-encoded RV32I words,
// error/saturation behaviour, FIFO backpressure, and asynchronous reset.
module tb_prirv32_instr_encoder;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [5:0]  req_op_i;
  logic [4:0]  req_rd_i, req_rs1_i, req_rs2_i;
  logic [31:0] req_imm_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic        out_err_o;
  logic [2:0]  fifo_level_o;
  logic [7:0]  err_count_o;

  int checks = 0;
  int errors = 0;
  int exp_errs = 0;

  prirv32_instr_encoder #(.FIFO_DEPTH(4)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_rd_i    (req_rd_i),
    .req_rs1_i   (req_rs1_i),
    .req_rs2_i   (req_rs2_i),
    .req_imm_i   (req_imm_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_instr_o (out_instr_o),
    .out_err_o   (out_err_o),
    .fifo_level_o(fifo_level_o),
    .err_count_o (err_count_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_rd_i    = rd;
    req_rs1_i   = rs1;
    req_rs2_i   = rs2;
    req_imm_i   = imm;
  endtask

  // One request through an empty FIFO with out_ready_i high: check the word, then let it pop.
  task automatic send(input string tag, input logic [5:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] exp_w, input logic exp_e);
    drive(op, rd, rs1, rs2, imm);
    step();
    req_valid_i = 1'b0;
    if (exp_e && exp_errs < 255) exp_errs++;
    check({tag, " valid"}, {31'b0, out_valid_o}, 32'd1);
    check({tag, " instr"}, out_instr_o, exp_w);
    check({tag, " err"}, {31'b0, out_err_o}, {31'b0, exp_e});
    check({tag, " err_count"}, {24'b0, err_count_o}, exp_errs);
    step();
    check({tag, " drained"}, {29'b0, fifo_level_o}, 32'd0);
  endtask

  initial begin
    req_valid_i = 1'b0;
    req_op_i    = '0;
    req_rd_i    = '0;
    req_rs1_i   = '0;
    req_rs2_i   = '0;
    req_imm_i   = '0;
    out_ready_i = 1'b1;
    rst_n       = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst valid", {31'b0, out_valid_o}, 32'd0);
    check("rst instr", out_instr_o, 32'd0);
    check("rst err", {31'b0, out_err_o}, 32'd0);
    check("rst level", {29'b0, fifo_level_o}, 32'd0);
    check("rst err_count", {24'b0, err_count_o}, 32'd0);
    check("rst ready", {31'b0, req_ready_o}, 32'd1);
    @(negedge clk_in);
    rst_n = 1'b1;
    step();

    // Encodings
    send("addi", 6'd18, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
    send("sub", 6'd28, 5'd3, 5'd1, 5'd2, 32'h0, 32'h4020_81B3, 1'b0);
    send("beq", 6'd4, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    send("jal", 6'd2, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    send("lui", 6'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send("lui bad", 6'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h0, 1'b1);
    send("op50", 6'd50, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0, 1'b1);
    send("jal odd", 6'd2, 5'd1, 5'd0, 5'd0, 32'h0000_0801, 32'h0, 1'b1);
    send("srai big", 6'd26, 5'd1, 5'd1, 5'd0, 32'd32, 32'h0, 1'b1);
    send("sw", 6'd17, 5'd0, 5'd2, 5'd3, 32'hFFFF_FFF8, 32'hFE31_2C23, 1'b0);
    send("srai", 6'd26, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030_D093, 1'b0);
    send("csrrw", 6'd41, 5'd1, 5'd2, 5'd0, 32'h0000_0300, 32'h3001_10F3, 1'b0);
    send("ecall", 6'd39, 5'd7, 5'd9, 5'd3, 32'h0000_0123, 32'h0000_0073, 1'b0);
    send("ebreak", 6'd40, 5'd7, 5'd9, 5'd3, 32'hFFFF_FFFF, 32'h0010_0073, 1'b0);

    // Backpressure: five back-to-back requests into a 4-deep FIFO
    out_ready_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(6'd18, 5'(k), 5'd0, 5'd0, 32'(k));
      step();
    end
    check("full level", {29'b0, fifo_level_o}, 32'd4);
    check("full ready", {31'b0, req_ready_o}, 32'd0);
    drive(6'd18, 5'd5, 5'd0, 5'd0, 32'd5);
    step();
    check("full hold level", {29'b0, fifo_level_o}, 32'd4);
    check("full head", out_instr_o, 32'h0010_0093);
    out_ready_i = 1'b1;
    step();
    check("pop1 level", {29'b0, fifo_level_o}, 32'd3);
    check("pop1 head", out_instr_o, 32'h0020_0113);
    check("pop1 ready", {31'b0, req_ready_o}, 32'd1);
    step();
    req_valid_i = 1'b0;
    check("pop2 level", {29'b0, fifo_level_o}, 32'd3);
    check("pop2 head", out_instr_o, 32'h0030_0193);
    step();
    check("pop3 head", out_instr_o, 32'h0040_0213);
    step();
    check("pop4 head", out_instr_o, 32'h0050_0293);
    check("pop4 level", {29'b0, fifo_level_o}, 32'd1);
    step();
    check("empty valid", {31'b0, out_valid_o}, 32'd0);
    check("empty instr", out_instr_o, 32'd0);

    // Simultaneous push and pop at level 2
    out_ready_i = 1'b0;
    drive(6'd18, 5'd6, 5'd0, 5'd0, 32'd6);
    step();
    drive(6'd18, 5'd7, 5'd0, 5'd0, 32'd7);
    step();
    drive(6'd18, 5'd8, 5'd0, 5'd0, 32'd8);
    out_ready_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    check("pushpop level", {29'b0, fifo_level_o}, 32'd2);
    check("pushpop head", out_instr_o, 32'h0070_0393);
    step();
    check("pushpop next", out_instr_o, 32'h0080_0413);
    step();

    // Error counter saturation
    drive(6'd63, 5'd0, 5'd0, 5'd0, 32'h0);
    for (int k = 0; k < 10; k++) step();
    check("errcnt +10", {24'b0, err_count_o}, 32'(exp_errs + 10));
    for (int k = 0; k < 250; k++) step();
    req_valid_i = 1'b0;
    check("errcnt sat", {24'b0, err_count_o}, 32'd255);
    step();
    step();
    check("errcnt hold", {24'b0, err_count_o}, 32'd255);

    // Asynchronous reset mid-burst at level 3
    out_ready_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(6'd63, 5'd0, 5'd0, 5'd0, 32'h0);
      step();
    end
    req_valid_i = 1'b0;
    check("pre-rst level", {29'b0, fifo_level_o}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst valid", {31'b0, out_valid_o}, 32'd0);
    check("midrst level", {29'b0, fifo_level_o}, 32'd0);
    check("midrst err_count", {24'b0, err_count_o}, 32'd0);
    check("midrst ready", {31'b0, req_ready_o}, 32'd1);
    @(negedge clk_in);
    rst_n = 1'b1;
    drive(6'd18, 5'd9, 5'd0, 5'd0, 32'd9);
    step();
    req_valid_i = 1'b0;
    check("postrst head", out_instr_o, 32'h0090_0493);
    check("postrst level", {29'b0, fifo_level_o}, 32'd1);
    check("postrst err", {31'b0, out_err_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
